mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 112 +++++++++++
 tb/tb_mem_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: two-port arbiter in front of a single-ported synchronous memory.
// One grant per cycle, one-cycle read return, saturating per-port grant counters.
module mem_arbiter #(
   parameter int DATA_W = 64,
   parameter int RR     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              p0_req,
   input  logic              p1_req,
   input  logic              p0_we,
   input  logic              p1_we,
   input  logic [31:0]       p0_addr,
   input  logic [31:0]       p1_addr,
   input  logic [DATA_W-1:0] p0_wdata,
   input  logic [DATA_W-1:0] p1_wdata,
   output logic              p0_gnt,
   output logic              p1_gnt,
   output logic              p0_rvalid,
   output logic              p1_rvalid,
   output logic [DATA_W-1:0] p0_rdata,
   output logic [DATA_W-1:0] p1_rdata,
   output logic              mem_rd_en,
   output logic              mem_wr_en,
   output logic [31:0]       mem_addr,
   output logic [DATA_W-1:0] mem_wr_data,
   input  logic [DATA_W-1:0] mem_rd_data,
   output logic [31:0]       p0_gcnt,
   output logic [31:0]       p1_gcnt
);

   logic              last;
   logic              pend_v;
   logic              pend_port;
   logic [DATA_W-1:0] hold0;
   logic [DATA_W-1:0] hold1;

   // last holds the most recently granted port; the other port wins a tie.
   always_comb begin
      p0_gnt = 1'b0;
      p1_gnt = 1'b0;
      if (!rst) begin
         if (p0_req && p1_req) begin
            if (RR != 0 && !last) begin
               p1_gnt = 1'b1;
            end else begin
               p0_gnt = 1'b1;
            end
         end else begin
            p0_gnt = p0_req;
            p1_gnt = p1_req;
         end
      end
   end

   always_comb begin
      mem_rd_en   = 1'b0;
      mem_wr_en   = 1'b0;
      mem_addr    = '0;
      mem_wr_data = '0;
      if (p0_gnt) begin
         mem_rd_en   = !p0_we;
         mem_wr_en   = p0_we;
         mem_addr    = p0_addr;
         mem_wr_data = p0_wdata;
      end else if (p1_gnt) begin
         mem_rd_en   = !p1_we;
         mem_wr_en   = p1_we;
         mem_addr    = p1_addr;
         mem_wr_data = p1_wdata;
      end
   end

   // Gating with rst drops a read whose return cycle coincides with reset.
   assign p0_rvalid = pend_v && !pend_port && !rst;
   assign p1_rvalid = pend_v &&  pend_port && !rst;
   assign p0_rdata  = rst ? '0 : (p0_rvalid ? mem_rd_data : hold0);
   assign p1_rdata  = rst ? '0 : (p1_rvalid ? mem_rd_data : hold1);

   always_ff @(posedge clk) begin
      if (rst) begin
         last      <= 1'b0;
         pend_v    <= 1'b0;
         pend_port <= 1'b0;
         hold0     <= '0;
         hold1     <= '0;
         p0_gcnt   <= '0;
         p1_gcnt   <= '0;
      end else begin
         if (p0_gnt || p1_gnt) begin
            last <= p1_gnt;
         end
         pend_v    <= (p0_gnt && !p0_we) || (p1_gnt && !p1_we);
         pend_port <= p1_gnt;
         if (p0_rvalid) begin
            hold0 <= mem_rd_data;
         end
         if (p1_rvalid) begin
            hold1 <= mem_rd_data;
         end
         if (p0_gnt && p0_gcnt != 32'hFFFF_FFFF) begin
            p0_gcnt <= p0_gcnt + 32'd1;
         end
         if (p1_gnt && p1_gcnt != 32'hFFFF_FFFF) begin
            p1_gcnt <= p1_gcnt + 32'd1;
         end
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// tb_mem_arbiter: directed and randomized checks of mem_arbiter (RR=1 and RR=0
// instances) against a transaction-level model of grants, reads and counters.
module tb_mem_arbiter;
   localparam int DW = 64;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          p0_req = 0, p1_req = 0, p0_we = 0, p1_we = 0;
   logic [31:0]   p0_addr = 0, p1_addr = 0;
   logic [DW-1:0] p0_wdata = 0, p1_wdata = 0;

   logic          p0_gnt, p1_gnt, p0_rvalid, p1_rvalid, mem_rd_en, mem_wr_en;
   logic [DW-1:0] p0_rdata, p1_rdata, mem_wr_data;
   logic [DW-1:0] mem_rd_data = '0;
   logic [31:0]   mem_addr, p0_gcnt, p1_gcnt;

   logic          f_p0_gnt, f_p1_gnt, f_p0_rvalid, f_p1_rvalid, f_rd_en, f_wr_en;
   logic [DW-1:0] f_p0_rdata, f_p1_rdata, f_wr_data;
   logic [31:0]   f_addr, f_p0_gcnt, f_p1_gcnt;

   mem_arbiter #(.DATA_W(DW), .RR(1)) dut (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
      .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
      .p0_gnt(p0_gnt), .p1_gnt(p1_gnt), .p0_rvalid(p0_rvalid), .p1_rvalid(p1_rvalid),
      .p0_rdata(p0_rdata), .p1_rdata(p1_rdata),
      .mem_rd_en(mem_rd_en), .mem_wr_en(mem_wr_en), .mem_addr(mem_addr),
      .mem_wr_data(mem_wr_data), .mem_rd_data(mem_rd_data),
      .p0_gcnt(p0_gcnt), .p1_gcnt(p1_gcnt)
   );

   mem_arbiter #(.DATA_W(DW), .RR(0)) dut_fp (
      .clk(clk), .rst(rst),
      .p0_req(p0_req), .p1_req(p1_req), .p0_we(p0_we), .p1_we(p1_we),
      .p0_addr(p0_addr), .p1_addr(p1_addr), .p0_wdata(p0_wdata), .p1_wdata(p1_wdata),
      .p0_gnt(f_p0_gnt), .p1_gnt(f_p1_gnt), .p0_rvalid(f_p0_rvalid), .p1_rvalid(f_p1_rvalid),
      .p0_rdata(f_p0_rdata), .p1_rdata(f_p1_rdata),
      .mem_rd_en(f_rd_en), .mem_wr_en(f_wr_en), .mem_addr(f_addr),
      .mem_wr_data(f_wr_data), .mem_rd_data('0),
      .p0_gcnt(f_p0_gcnt), .p1_gcnt(f_p1_gcnt)
   );

   // Registered memory behind the RR=1 instance; 16 words indexed by addr[3:0].
   logic [DW-1:0] env_mem [16];
   initial for (int i = 0; i < 16; i++) env_mem[i] = '0;
   always @(posedge clk) begin
      if (mem_wr_en) env_mem[mem_addr[3:0]] <= mem_wr_data;
      if (mem_rd_en) mem_rd_data <= env_mem[mem_addr[3:0]];
   end

   int checks = 0;
   int passes = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act === exp) passes++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   // Transaction-level model state
   bit            m_last;
   bit            m_pv, m_pp;
   logic [DW-1:0] m_pdata;
   logic [DW-1:0] m_hold [2];
   logic [31:0]   m_gcnt [2];
   logic [31:0]   f_gcnt [2];
   logic [DW-1:0] m_mem  [16];
   int            last_eg = -1;

   task automatic step();
      int            eg, fg;
      logic          we;
      logic [31:0]   ad;
      logic [DW-1:0] wd;
      logic [1:0]    rv;
      @(negedge clk);
      if (rst) eg = -1;
      else if (p0_req && p1_req) eg = m_last ? 0 : 1;
      else if (p0_req) eg = 0;
      else if (p1_req) eg = 1;
      else eg = -1;
      fg = rst ? -1 : (p0_req ? 0 : (p1_req ? 1 : -1));
      we = (eg == 1) ? p1_we : p0_we;
      ad = (eg == 1) ? p1_addr : (eg == 0) ? p0_addr : 32'd0;
      wd = (eg == 1) ? p1_wdata : (eg == 0) ? p0_wdata : '0;
      rv[0] = !rst && m_pv && !m_pp;
      rv[1] = !rst && m_pv && m_pp;

      chk("p0_gnt", p0_gnt, eg == 0);
      chk("p1_gnt", p1_gnt, eg == 1);
      chk("mem_wr_en", mem_wr_en, eg >= 0 && we);
      chk("mem_rd_en", mem_rd_en, eg >= 0 && !we);
      chk("mem_addr", mem_addr, ad);
      chk("mem_wr_data", mem_wr_data, wd);
      chk("p0_rvalid", p0_rvalid, rv[0]);
      chk("p1_rvalid", p1_rvalid, rv[1]);
      chk("p0_rdata", p0_rdata, rst ? '0 : (rv[0] ? m_pdata : m_hold[0]));
      chk("p1_rdata", p1_rdata, rst ? '0 : (rv[1] ? m_pdata : m_hold[1]));
      chk("p0_gcnt", p0_gcnt, m_gcnt[0]);
      chk("p1_gcnt", p1_gcnt, m_gcnt[1]);
      chk("fp_p0_gnt", f_p0_gnt, fg == 0);
      chk("fp_p1_gnt", f_p1_gnt, fg == 1);
      chk("fp_p0_gcnt", f_p0_gcnt, f_gcnt[0]);
      chk("fp_p1_gcnt", f_p1_gcnt, f_gcnt[1]);

      if (rst) begin
         m_last = 0; m_pv = 0; m_pp = 0;
         m_hold[0] = '0; m_hold[1] = '0;
         m_gcnt[0] = 0; m_gcnt[1] = 0; f_gcnt[0] = 0; f_gcnt[1] = 0;
      end else begin
         for (int k = 0; k < 2; k++) if (rv[k]) m_hold[k] = m_pdata;
         m_pv = 0;
         if (eg >= 0) begin
            m_last = (eg == 1);
            if (m_gcnt[eg] != 32'hFFFF_FFFF) m_gcnt[eg] = m_gcnt[eg] + 1;
            if (we) m_mem[ad[3:0]] = wd;
            else begin
               m_pv = 1; m_pp = (eg == 1); m_pdata = m_mem[ad[3:0]];
            end
         end
         if (fg >= 0 && f_gcnt[fg] != 32'hFFFF_FFFF) f_gcnt[fg] = f_gcnt[fg] + 1;
      end
      last_eg = eg;
      @(posedge clk);
      #1;
   endtask

   task automatic set_p0(input logic req, input logic we, input logic [31:0] a, input logic [DW-1:0] d);
      p0_req = req; p0_we = we; p0_addr = a; p0_wdata = d;
   endtask

   task automatic set_p1(input logic req, input logic we, input logic [31:0] a, input logic [DW-1:0] d);
      p1_req = req; p1_we = we; p1_addr = a; p1_wdata = d;
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      set_p0(0, 0, 0, 0);
      set_p1(0, 0, 0, 0);
      repeat (n) step();
      rst = 1'b0;
   endtask

   // A port holds its request until granted, then draws a fresh one.
   task automatic rand_drive();
      if (!(p0_req && last_eg != 0))
         set_p0($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom & 32'hFF00_000F, {$urandom, $urandom});
      if (!(p1_req && last_eg != 1))
         set_p1($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                $urandom & 32'hFF00_000F, {$urandom, $urandom});
   endtask

   initial begin
      for (int i = 0; i < 16; i++) m_mem[i] = '0;
      m_hold[0] = '0; m_hold[1] = '0;
      m_gcnt[0] = 0; m_gcnt[1] = 0; f_gcnt[0] = 0; f_gcnt[1] = 0;
      m_pdata = '0;
      @(posedge clk); #1;

      // Reset, including requests presented while rst is high
      do_reset(1);
      rst = 1'b1;
      set_p0(1, 0, 3, 0);
      set_p1(1, 1, 4, 7);
      #1;
      chk("rst_p0_gnt", p0_gnt, 0);
      chk("rst_mem_strobes", {mem_rd_en, mem_wr_en}, 0);
      step();
      do_reset(1);
      chk("rst_gcnt", p0_gcnt, 0);

      // Write then read the same address on p0
      set_p0(1, 1, 5, 64'hAA);
      #1;
      chk("wr5_gnt", p0_gnt, 1);
      chk("wr5_wr_en", mem_wr_en, 1);
      step();
      set_p0(1, 0, 5, 0);
      #1;
      chk("rd5_gnt", p0_gnt, 1);
      step();
      set_p0(0, 0, 0, 0);
      #1;
      chk("rd5_rvalid", p0_rvalid, 1);
      chk("rd5_rdata", p0_rdata, 64'hAA);
      chk("rd5_gcnt", p0_gcnt, 2);
      step();
      chk("rd5_hold", p0_rdata, 64'hAA);

      // Continuous contention from reset: p1 wins first, then alternation
      do_reset(1);
      set_p0(1, 0, 5, 0);
      set_p1(1, 0, 6, 0);
      for (int i = 0; i < 6; i++) begin
         #1;
         chk("rr_p1_gnt", p1_gnt, (i % 2) == 0);
         chk("fp_p0_always", f_p0_gnt, 1);
         step();
      end
      set_p0(0, 0, 0, 0);
      set_p1(0, 0, 0, 0);
      #1;
      chk("rr_p0_gcnt", p0_gcnt, 3);
      chk("rr_p1_gcnt", p1_gcnt, 3);
      chk("fp_p1_gcnt_zero", f_p1_gcnt, 0);
      step();

      // Reset arriving in the return cycle of a read
      set_p0(1, 0, 5, 0);
      step();
      rst = 1'b1;
      set_p0(1, 0, 5, 0);
      #1;
      chk("rstrd_rvalid", p0_rvalid, 0);
      chk("rstrd_strobes", {mem_rd_en, mem_wr_en}, 0);
      step();
      chk("rstrd_gcnt", p0_gcnt, 0);
      do_reset(1);

      // Write from p0 observed by a following read from p1
      set_p0(1, 1, 9, 64'h1234);
      step();
      set_p0(0, 0, 0, 0);
      set_p1(1, 0, 9, 0);
      step();
      set_p1(0, 0, 0, 0);
      #1;
      chk("x_p1_rvalid", p1_rvalid, 1);
      chk("x_p1_rdata", p1_rdata, 64'h1234);
      chk("x_p0_rvalid", p0_rvalid, 0);
      step();

      // Counter saturation
      force dut.p0_gcnt = 32'hFFFF_FFFE;
      #1;
      release dut.p0_gcnt;
      m_gcnt[0] = 32'hFFFF_FFFE;
      set_p0(1, 0, 2, 0);
      step();
      step();
      set_p0(0, 0, 0, 0);
      #1;
      chk("sat_gcnt", p0_gcnt, 32'hFFFF_FFFF);
      step();
      chk("sat_hold", p0_gcnt, 32'hFFFF_FFFF);

      // Randomized traffic with occasional resets
      for (int i = 0; i < 600; i++) begin
         rst = ($urandom_range(0, 59) == 0);
         rand_drive();
         step();
      end
      rst = 1'b0;
      set_p0(0, 0, 0, 0);
      set_p1(0, 0, 0, 0);
      step();

      $display("%0d/%0d checks passed", passes, checks);
      $finish;
   end

endmodule
`default_nettype wire
